dma_region_guard: RTL and testbench

Parametrised DMA access monitor for the VRASED hardware module. It generalises the fixed two-region DMA guard (secure data plus counter) to NREG independently configured address regions. Each region has its own deny mode: any access, or writes only. The block adds a minimum reset-hold interval and records which region was violated and where. It sits beside the other hw-mod monitors; its `reset` output is ORed into the MCU reset request.

---
 rtl/dma_guard_pkg.sv | 28 ++
 rtl/dma_region_match.sv | 23 ++
 rtl/dma_region_guard.sv | 107 ++++++++++
 tb/tb_dma_region_guard.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_guard_pkg.sv
// Shared constants and types for the DMA region guard: FSM encoding,
// default VRASED region map and violation record layout.
package dma_guard_pkg;

  localparam logic ST_KILL = 1'b1;
  localparam logic ST_RUN  = 1'b0;

  localparam logic [15:0] SDATA_BASE = 16'h0400;
  localparam logic [15:0] SDATA_SIZE = 16'h0C00;
  localparam logic [15:0] CTR_BASE   = 16'h9000;
  localparam logic [15:0] CTR_SIZE   = 16'h001F;

  localparam logic [15:0] DEFAULT_RESET_HANDLER = 16'h0000;

  localparam int ID_W   = 3;
  localparam int CNT_W  = 8;
  localparam int HOLD_W = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [15:0]      addr;
    logic [CNT_W-1:0] cnt;
  } viol_rec_t;

endpackage

// File: rtl/dma_region_match.sv
// Single-region DMA address check; compares in 17 bits so a region may end
// exactly at 0x10000 without wrapping.
module dma_region_match #(
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [15:0] SIZE = 16'h0000,
  parameter logic        MODE = 1'b1
) (
  input  logic [15:0] addr,
  input  logic        en,
  input  logic        we,
  output logic        deny
);

  localparam logic [16:0] LO = {1'b0, BASE};
  localparam logic [16:0] HI = {1'b0, BASE} + {1'b0, SIZE};

  logic w_hit;

  assign w_hit = en && (SIZE != 16'h0000) &&
                 ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
  assign deny  = w_hit && (MODE || we);

endmodule

// File: rtl/dma_region_guard.sv
// DMA access monitor over NREG regions: holds the MCU in reset after a
// denied access and keeps a record of the first cause of each kill.
module dma_region_guard
  import dma_guard_pkg::*;
#(
  parameter int                NREG          = 2,
  parameter logic [16*NREG-1:0] REGION_BASE  = {CTR_BASE, SDATA_BASE},
  parameter logic [16*NREG-1:0] REGION_SIZE  = {CTR_SIZE, SDATA_SIZE},
  parameter logic [NREG-1:0]   REGION_MODE   = 2'b11,
  parameter logic [15:0]       RESET_HANDLER = DEFAULT_RESET_HANDLER,
  parameter int                HOLD_CYCLES   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      pc,
  input  logic [15:0]      dma_addr,
  input  logic             dma_en,
  input  logic             dma_we,
  output logic             reset,
  output logic             viol_valid,
  output logic [ID_W-1:0]  viol_id,
  output logic [15:0]      viol_addr,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

  logic [NREG-1:0]   w_deny;
  logic              w_viol;
  logic [ID_W-1:0]   w_id;

  logic              r_state;
  logic [HOLD_W-1:0] r_hold;
  viol_rec_t         r_rec;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_region
      dma_region_match #(
        .BASE (REGION_BASE[16*gi +: 16]),
        .SIZE (REGION_SIZE[16*gi +: 16]),
        .MODE (REGION_MODE[gi])
      ) u_match (
        .addr (dma_addr),
        .en   (dma_en),
        .we   (dma_we),
        .deny (w_deny[gi])
      );
    end
  endgenerate

  assign w_viol = |w_deny;

  // Scan from the top down so the lowest denying index wins on overlap.
  always_comb begin
    w_id = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (w_deny[i]) begin
        w_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_KILL;
      r_hold  <= HOLD_INIT;
      r_rec   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_viol) begin
            r_state     <= ST_KILL;
            r_hold      <= HOLD_INIT;
            r_rec.valid <= 1'b1;
            r_rec.id    <= w_id;
            r_rec.addr  <= dma_addr;
            if (r_rec.cnt != CNT_MAX) begin
              r_rec.cnt <= r_rec.cnt + 1'b1;
            end
          end
        end
        default: begin
          // A repeat violation while killed only restarts the hold window;
          // the record keeps the access that caused the kill.
          if (w_viol) begin
            r_hold <= HOLD_INIT;
          end else begin
            if (r_hold == '0 && pc == RESET_HANDLER) begin
              r_state <= ST_RUN;
            end
            if (r_hold != '0) begin
              r_hold <= r_hold - 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign reset      = (r_state == ST_KILL);
  assign viol_valid = r_rec.valid;
  assign viol_id    = r_rec.id;
  assign viol_addr  = r_rec.addr;
  assign viol_cnt   = r_rec.cnt;

endmodule

// File: tb/tb_dma_region_guard.sv
// Scoreboard bench for dma_region_guard: three configurations share one
// input bus; the driver queues expectations, a monitor checks after each edge.
module tb_dma_region_guard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic        dma_we;

  logic        a_rst, b_rst, c_rst;
  logic        a_vv, b_vv, c_vv;
  logic [2:0]  a_id, b_id, c_id;
  logic [15:0] a_addr, b_addr, c_addr;
  logic [7:0]  a_cnt, b_cnt, c_cnt;

  always #5 clk = ~clk;

  // Defaults: SDATA 0x0400/0x0C00, CTR 0x9000/0x001F, both deny any access.
  dma_region_guard u_a (
    .clk(clk), .reset_n(reset_n), .pc(pc), .dma_addr(dma_addr),
    .dma_en(dma_en), .dma_we(dma_we), .reset(a_rst), .viol_valid(a_vv),
    .viol_id(a_id), .viol_addr(a_addr), .viol_cnt(a_cnt)
  );

  // Region 1 write-only, legacy zero hold.
  dma_region_guard #(
    .REGION_MODE(2'b01), .HOLD_CYCLES(0)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .pc(pc), .dma_addr(dma_addr),
    .dma_en(dma_en), .dma_we(dma_we), .reset(b_rst), .viol_valid(b_vv),
    .viol_id(b_id), .viol_addr(b_addr), .viol_cnt(b_cnt)
  );

  // Overlapping regions plus one ending exactly at 0x10000.
  dma_region_guard #(
    .NREG(3),
    .REGION_BASE({16'hFFF0, 16'h0800, 16'h0400}),
    .REGION_SIZE({16'h0010, 16'h1000, 16'h0C00}),
    .REGION_MODE(3'b111),
    .HOLD_CYCLES(0)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .pc(pc), .dma_addr(dma_addr),
    .dma_en(dma_en), .dma_we(dma_we), .reset(c_rst), .viol_valid(c_vv),
    .viol_id(c_id), .viol_addr(c_addr), .viol_cnt(c_cnt)
  );

  typedef struct {
    int          sel;
    int          step;
    bit          rec;
    logic        rst;
    logic        vv;
    logic [2:0]  id;
    logic [15:0] addr;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  task automatic chk(input string what, input int sel, input int stp,
                     input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut=%0d step=%0d got=%h want=%h", what, sel, stp, got, want);
    end
  endtask

  task automatic get_out(input int sel, output logic r, output logic vv,
                         output logic [2:0] id, output logic [15:0] ad,
                         output logic [7:0] cn);
    case (sel)
      0:       begin r = a_rst; vv = a_vv; id = a_id; ad = a_addr; cn = a_cnt; end
      1:       begin r = b_rst; vv = b_vv; id = b_id; ad = b_addr; cn = b_cnt; end
      default: begin r = c_rst; vv = c_vv; id = c_id; ad = c_addr; cn = c_cnt; end
    endcase
  endtask

  task automatic compare(input exp_t e);
    logic        r, vv;
    logic [2:0]  id;
    logic [15:0] ad;
    logic [7:0]  cn;
    get_out(e.sel, r, vv, id, ad, cn);
    $display("step %0d dut=%0d reset=%0b valid=%0b id=%0d addr=%h cnt=%0d",
             e.step, e.sel, r, vv, id, ad, cn);
    chk("reset", e.sel, e.step, {15'd0, r}, {15'd0, e.rst});
    if (e.rec) begin
      chk("viol_valid", e.sel, e.step, {15'd0, vv}, {15'd0, e.vv});
      chk("viol_id",    e.sel, e.step, {13'd0, id}, {13'd0, e.id});
      chk("viol_addr",  e.sel, e.step, ad, e.addr);
      chk("viol_cnt",   e.sel, e.step, {8'd0, cn}, {8'd0, e.cnt});
    end
  endtask

  // Monitor: one expectation per clock, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e);
      end
    end
  end

  // Drive one cycle (called at a negedge) and queue the post-edge expectation.
  task automatic cyc(input logic [15:0] p, input logic [15:0] a,
                     input logic en, input logic we, input int sel, input bit rec,
                     input logic r, input logic vv, input logic [2:0] id,
                     input logic [15:0] va, input logic [7:0] cn);
    exp_t e;
    pc = p; dma_addr = a; dma_en = en; dma_we = we;
    step++;
    e.sel = sel; e.step = step; e.rec = rec; e.rst = r;
    e.vv = vv; e.id = id; e.addr = va; e.cnt = cn;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    exp_t e;
    pc = 16'h0000; dma_addr = 16'h0000; dma_en = 1'b0; dma_we = 1'b0;
    reset_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      step++;
      e.sel = s; e.step = step; e.rec = 1'b1; e.rst = 1'b1;
      e.vv = 1'b0; e.id = 3'd0; e.addr = 16'h0000; e.cnt = 8'd0;
      compare(e);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wait_cnt;
    logic [15:0] ea;
    logic [2:0]  eid;
    logic [7:0]  ec;
    reset_n = 1'b1;
    pc = 16'h0000; dma_addr = 16'h0000; dma_en = 1'b0; dma_we = 1'b0;
    #3;
    do_reset();

    // Config A: hold of 3, exit after edge 4.
    for (int i = 0; i < 3; i++) cyc(16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 0);
    cyc(16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0);
    cyc(16'h0000, 16'h0400, 1, 0, 0, 1, 1, 1, 0, 16'h0400, 1);
    for (int i = 0; i < 4; i++) cyc(16'h1234, 16'h0000, 0, 0, 0, 1, 1, 1, 0, 16'h0400, 1);
    cyc(16'h0000, 16'h0FFF, 1, 0, 0, 1, 1, 1, 0, 16'h0400, 1);
    for (int i = 0; i < 3; i++) cyc(16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 0, 16'h0400, 1);
    cyc(16'h0000, 16'h0000, 0, 0, 0, 1, 0, 1, 0, 16'h0400, 1);
    cyc(16'h0000, 16'h1000, 1, 1, 0, 1, 0, 1, 0, 16'h0400, 1);
    cyc(16'h0000, 16'h901F, 1, 0, 0, 1, 0, 1, 0, 16'h0400, 1);
    cyc(16'h0000, 16'h9000, 1, 0, 0, 1, 1, 1, 1, 16'h9000, 2);
    do_reset();

    // Config B: write-only region 1, zero hold.
    cyc(16'h0000, 16'h0000, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 0);
    cyc(16'h0000, 16'h9000, 1, 0, 1, 1, 0, 0, 0, 16'h0000, 0);
    cyc(16'h0000, 16'h901F, 1, 1, 1, 1, 0, 0, 0, 16'h0000, 0);
    cyc(16'h0000, 16'h03FF, 1, 1, 1, 1, 0, 0, 0, 16'h0000, 0);
    cyc(16'h0000, 16'h901E, 1, 1, 1, 1, 1, 1, 1, 16'h901E, 1);
    cyc(16'h0000, 16'h0400, 1, 0, 1, 1, 1, 1, 1, 16'h901E, 1);
    cyc(16'h0000, 16'h0000, 0, 0, 1, 1, 0, 1, 1, 16'h901E, 1);
    do_reset();

    // Config C: overlap priority, top-of-memory region, counter saturation.
    cyc(16'h0000, 16'h0000, 0, 0, 2, 1, 0, 0, 0, 16'h0000, 0);
    cyc(16'h0000, 16'h1800, 1, 1, 2, 1, 0, 0, 0, 16'h0000, 0);
    cyc(16'h0000, 16'hFFFF, 1, 0, 2, 1, 1, 1, 2, 16'hFFFF, 1);
    cyc(16'h0000, 16'h0000, 0, 0, 2, 1, 0, 1, 2, 16'hFFFF, 1);
    for (int k = 2; k <= 257; k++) begin
      ea  = (k % 2 == 1) ? 16'h1200 : 16'h0900;
      eid = (k % 2 == 1) ? 3'd1 : 3'd0;
      ec  = (k >= 255) ? 8'd255 : 8'(k);
      cyc(16'h0000, ea, 1, 0, 2, 1, 1, 1, eid, ea, ec);
      cyc(16'h0000, 16'h0000, 0, 0, 2, 1, 0, 1, eid, ea, ec);
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
